// File: rtl/cmd_pkg.sv
// Shared types and constants for the command frame parser.
package cmd_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
  localparam int unsigned MAX_BYTES     = 15;

  // Mode codes carried in para1.
  localparam logic [7:0] MODE_RECT = 8'd2;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck,
    StDrop
  } state_e;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte gap timer: counts cycles since the last byte, flags expiry at IDLE_TICKS-1.
module idle_timer #(
  parameter int unsigned IDLE_TICKS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned W = $clog2(IDLE_TICKS);
  localparam logic [W-1:0] LAST = W'(IDLE_TICKS - 1);

  logic [W-1:0] cnt_q;

  // The clearing byte's own cycle is cycle 0, so the next cycle reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= W'(1);
    end else if (run && !expire) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/cmd_parser.sv
// Header-delimited command frame parser; a frame ends after an inter-byte idle gap.
// Optional trailing checksum byte enabled by defining CMD_CHECKSUM_EN.
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int unsigned IDLE_TICKS = 100000,
  parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cmd_clr,
  output logic [7:0] para1,
  output logic [7:0] para2,
  output logic [7:0] para3,
  output logic [3:0] data_num,
  output logic       new_cmd,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

`ifdef CMD_CHECKSUM_EN
  localparam logic [3:0] OVERHEAD = 4'd2;
`else
  localparam logic [3:0] OVERHEAD = 4'd1;
`endif

  state_e     state_q;
  logic [3:0] count_q;
  logic [7:0] acc_q;
  logic [7:0] last_q;
  logic [7:0] shadow1_q;
  logic [7:0] shadow2_q;
  logic [7:0] shadow3_q;

  logic       is_header;
  logic       start_frame;
  logic       timer_clear;
  logic       timer_run;
  logic       gap_expired;
  logic       sum_ok;
  logic       frame_ok;
  logic [3:0] payload;

  assign is_header   = rx_valid && (rx_data == HEADER);
  // A header during CHECK starts the next frame in the same cycle.
  assign start_frame = is_header && ((state_q == StIdle) || (state_q == StCheck));
  assign timer_run   = (state_q == StRecv) || (state_q == StDrop);
  assign timer_clear = start_frame || (timer_run && rx_valid);

`ifdef CMD_CHECKSUM_EN
  assign sum_ok = (acc_q - last_q) == last_q;
`else
  assign sum_ok = 1'b1;
  logic unused_sum;
  assign unused_sum = ^{acc_q, last_q};
`endif

  assign frame_ok = (count_q > OVERHEAD) && sum_ok;
  assign payload  = count_q - OVERHEAD;

  idle_timer #(
    .IDLE_TICKS(IDLE_TICKS)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .run   (timer_run),
    .expire(gap_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      last_q    <= '0;
      shadow1_q <= '0;
      shadow2_q <= '0;
      shadow3_q <= '0;
      para1     <= '0;
      para2     <= '0;
      para3     <= '0;
      data_num  <= '0;
      new_cmd   <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      new_cmd   <= 1'b0;
      frame_err <= 1'b0;
      if (cmd_clr) begin
        data_num <= '0;
      end

      unique case (state_q)
        StIdle: ;
        StRecv: begin
          if (rx_valid) begin
            if (count_q == 4'(MAX_BYTES)) begin
              state_q <= StDrop;
            end else begin
              count_q <= count_q + 4'd1;
              acc_q   <= acc_q + rx_data;
              last_q  <= rx_data;
              case (count_q)
                4'd1:    shadow1_q <= rx_data;
                4'd2:    shadow2_q <= rx_data;
                4'd3:    shadow3_q <= rx_data;
                default: ;
              endcase
            end
          end else if (gap_expired) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          state_q <= StIdle;
          if (frame_ok) begin
            // Assigned after the cmd_clr default, so an accept wins.
            data_num <= count_q;
            para1    <= shadow1_q;
            para2    <= (payload >= 4'd2) ? shadow2_q : 8'h00;
            para3    <= (payload >= 4'd3) ? shadow3_q : 8'h00;
            new_cmd  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        StDrop: begin
          if (!rx_valid && gap_expired) begin
            state_q   <= StIdle;
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (start_frame) begin
        state_q   <= StRecv;
        count_q   <= 4'd1;
        acc_q     <= '0;
        shadow1_q <= '0;
        shadow2_q <= '0;
        shadow3_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser with IDLE_TICKS=16; expectations follow CMD_CHECKSUM_EN.
module tb_cmd_parser;

  localparam int unsigned TICKS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_clr;
  logic [7:0] para1;
  logic [7:0] para2;
  logic [7:0] para3;
  logic [3:0] data_num;
  logic       new_cmd;
  logic       frame_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  cmd_parser #(
    .IDLE_TICKS(TICKS),
    .HEADER    (8'hAA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_clr  (cmd_clr),
    .para1    (para1),
    .para2    (para2),
    .para3    (para3),
    .data_num (data_num),
    .new_cmd  (new_cmd),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int n_new = 0;
  int n_ferr = 0;
  int n_both = 0;
  int t_new = 0;
  always @(negedge clk) begin
    if (new_cmd === 1'b1) begin
      n_new = n_new + 1;
      t_new = cyc;
    end
    if (frame_err === 1'b1) n_ferr = n_ferr + 1;
    if (new_cmd === 1'b1 && frame_err === 1'b1) n_both = n_both + 1;
  end

  int n_vec = 0;
  int n_bad = 0;
  int t_last = 0;
  int base_new = 0;
  int base_ferr = 0;
  int exp_err = 0;
  logic [7:0] e_p1, e_p2, e_p3;
  logic [3:0] e_dn;
  logic [7:0] fq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    t_last   = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fq[i]) send(fq[i]);
  endtask

  task automatic gap();
    repeat (TICKS + 4) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    base_new  = n_new;
    base_ferr = n_ferr;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    cmd_clr = 1'b1;
    @(posedge clk);
    #1;
    cmd_clr = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_new, input int exp_ferr);
    check({tag, ".new"}, n_new - base_new, exp_new);
    check({tag, ".ferr"}, n_ferr - base_ferr, exp_ferr);
    check({tag, ".dn"}, data_num, e_dn);
    check({tag, ".p1"}, para1, e_p1);
    check({tag, ".p2"}, para2, e_p2);
    check({tag, ".p3"}, para3, e_p3);
    check({tag, ".errcnt"}, err_cnt, exp_err);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cmd_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    e_dn = 4'd0; e_p1 = 8'h00; e_p2 = 8'h00; e_p3 = 8'h00;
    check("rst.new", new_cmd, 0);
    check("rst.ferr", frame_err, 0);
    check("rst.dn", data_num, 0);
    check("rst.p1", para1, 0);
    check("rst.p2", para2, 0);
    check("rst.p3", para3, 0);
    check("rst.errcnt", err_cnt, 0);

    // Basic frame; with checksum on, 09 = 02+03+04.
    mark();
    fq = '{8'hAA, 8'h02, 8'h03, 8'h04, 8'h09};
    send_frame();
    gap();
    e_dn = 4'd5; e_p1 = 8'h02; e_p2 = 8'h03; e_p3 = 8'h04;
    check_frame("A", 1, 0);
    check("A.lat", t_new - t_last, TICKS + 1);

    // Bad checksum byte 0A.
    mark();
    fq = '{8'hAA, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_frame();
    gap();
`ifdef CMD_CHECKSUM_EN
    exp_err = exp_err + 1;
    check_frame("B", 0, 1);
`else
    check_frame("B", 1, 0);
`endif

    // 16 bytes: overflow, dropped.
    mark();
    fq.delete();
    fq.push_back(8'hAA);
    for (int i = 1; i < 16; i++) fq.push_back(8'(i));
    send_frame();
    gap();
    exp_err = exp_err + 1;
    check_frame("ovf", 0, 1);

    // Garbage before header is ignored; 0D = 02+05+06.
    mark();
    fq = '{8'h12, 8'h34, 8'hAA, 8'h02, 8'h05, 8'h06, 8'h0D};
    send_frame();
    gap();
    e_dn = 4'd5; e_p1 = 8'h02; e_p2 = 8'h05; e_p3 = 8'h06;
    check_frame("C", 1, 0);

    // Short frame AA 01.
    mark();
    fq = '{8'hAA, 8'h01};
    send_frame();
    gap();
`ifdef CMD_CHECKSUM_EN
    exp_err = exp_err + 1;
    check_frame("D", 0, 1);
`else
    e_dn = 4'd2; e_p1 = 8'h01; e_p2 = 8'h00; e_p3 = 8'h00;
    check_frame("D", 1, 0);
`endif

    // Header alone: no payload.
    mark();
    fq = '{8'hAA};
    send_frame();
    gap();
    exp_err = exp_err + 1;
    check_frame("E", 0, 1);

    pulse_clr();
    check("clr0.dn", data_num, 0);

    // cmd_clr in the CHECK cycle: the accept must win.
    mark();
    fq = '{8'hAA, 8'h02, 8'h03, 8'h04, 8'h09};
    send_frame();
    repeat (TICKS - 1) @(posedge clk);
    #1;
    cmd_clr = 1'b1;
    @(posedge clk);
    #1;
    cmd_clr = 1'b0;
    check("F.newnow", new_cmd, 1);
    check("F.dnnow", data_num, 5);
    gap();
    e_dn = 4'd5; e_p1 = 8'h02; e_p2 = 8'h03; e_p3 = 8'h04;
    check_frame("F", 1, 0);

    // Lone cmd_clr clears data_num only.
    mark();
    pulse_clr();
    e_dn = 4'd0;
    check_frame("clr", 0, 0);

    // Reset mid-frame: no pulses, everything back to zero.
    mark();
    send(8'hAA);
    send(8'h07);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gap();
    exp_err = 0;
    e_dn = 4'd0; e_p1 = 8'h00; e_p2 = 8'h00; e_p3 = 8'h00;
    check_frame("rstmid", 0, 0);

    // 256 rejected frames saturate err_cnt at 255.
    mark();
    fq = '{8'hAA};
    for (int k = 0; k < 256; k++) begin
      send_frame();
      gap();
    end
    check("sat.ferr", n_ferr - base_ferr, 256);
    check("sat.errcnt", err_cnt, 255);
    check("sat.new", n_new - base_new, 0);

    check("excl", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
# cmd_parser

Frame parser between the UART byte receiver and the motion generators. It assembles header-delimited command frames from a byte stream, and uses an inter-byte idle gap to mark the end of a frame. For each valid frame it atomically publishes para1/para2/para3 and the frame byte count data_num, which all motion stages decode (mode in para1, geometry in para2/para3).

## Interface
- IDLE_TICKS, 100000: idle-gap length in clk cycles that ends a frame (2 ms at 50 MHz); legal range 4..2^20.
- HEADER, 8'hAA: frame start byte.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- cmd_clr  in  1  one-cycle request to disarm the current command.
- para1  out  8  frame byte 1 (mode).
- para2  out  8  frame byte 2.
- para3  out  8  frame byte 3.
- data_num  out  4  total bytes of the last accepted frame, header included.
- new_cmd  out  1  one-cycle pulse when outputs update.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_cnt  out  8  rejected-frame count, saturating at 255.

## Operation
- Reset values: para1/2/3=0, data_num=0, new_cmd=0, frame_err=0, err_cnt=0, state IDLE.
- IDLE: bytes other than HEADER are ignored. On HEADER: byte count=1, checksum accumulator=0, shadow regs=0, gap timer cleared, go to RECV.
- RECV: each byte increments the count, is added mod 256 to the accumulator, and is stored as last_byte. Bytes 1..3 go to shadow1..3; later bytes are counted only. HEADER in RECV is ordinary data. Each byte clears the gap timer.
- The 16th byte (count would exceed 15) is overflow: go to DROP. DROP ignores bytes, restarts the gap timer on each byte, and at gap expiry pulses frame_err and returns to IDLE.
- At gap expiry in RECV, go to CHECK for one cycle.
- CHECK: payload count P = count-1 (count-2 with checksum). Reject when P<1 or the checksum fails. On reject: pulse frame_err, err_cnt+1 saturating, outputs unchanged. On accept: data_num=count; para_k = shadow_k when k≤P, else 0; pulse new_cmd.
- A byte arriving during CHECK is handled with IDLE rules (HEADER starts a new frame) in the same cycle.
- cmd_clr sets data_num=0; para regs hold. If cmd_clr coincides with an accept, the accept wins.
- Reset mid-frame discards the partial frame with no error pulse.

## Timing
- Gap timer counts cycles since the last byte. Expiry is the cycle it reaches IDLE_TICKS-1.
- Last byte's rx_valid in cycle t: CHECK in cycle t+IDLE_TICKS, outputs and pulses visible in cycle t+IDLE_TICKS+1.
- para1..3 and data_num change only on the same edge: never partially updated.
- new_cmd and frame_err are mutually exclusive, each exactly one cycle wide.

## Configuration
- CMD_CHECKSUM_EN defined: the last frame byte is a checksum. It must equal the mod-256 sum of all bytes between header and checksum (accumulator minus last_byte). The checksum byte counts in data_num but never lands in a para output. A mismatch rejects the frame.
- Not defined: no checksum byte and no checksum comparison. All bytes after the header are payload.

## Structure
- Package cmd_pkg: HEADER default, MAX_BYTES=15, state enum (IDLE, RECV, CHECK, DROP), mode codes (2 = rectangle).
- Sub-module idle_timer: loadable counter with clear input and expire output, parameterised by IDLE_TICKS.
- Accumulator and shadow regs live in cmd_parser.

## Test plan
- IDLE_TICKS=16, checksum on; send AA 02 03 04 09 then idle → data_num=5, para=02/03/04, new_cmd one pulse 17 cycles after the last strobe.
- Same frame with checksum byte 0A → frame_err pulse, err_cnt=1, outputs keep previous values.
- Send 16 bytes starting AA then idle → frame_err once, back to IDLE; a following valid frame is accepted.
- Checksum off; send AA 01 then idle → data_num=2, para1=01, para2=para3=0.
- Send garbage 12 34 then AA 02 05 06 0D → garbage ignored; accept with data_num=5.
- Assert cmd_clr in the same cycle as CHECK accept → data_num=5. A later cmd_clr alone → data_num=0, paras held.
